// File: rtl/imem_loader.sv
// Boot-time byte-stream loader: captures an 8-byte little-endian entry PC, then writes the body
// into instruction memory. Define IMEM_LOADER_CKSUM_EN to treat the in_last byte as an XOR checksum.
module imem_loader #(
    parameter int unsigned MEM_BYTES = 1024,
    parameter int unsigned CNT_W     = 11
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load_req,
    input  logic             in_valid,
    input  logic [7:0]       in_data,
    input  logic             in_last,
    output logic             in_ready,
    output logic             mem_we,
    output logic [63:0]      mem_addr,
    output logic [7:0]       mem_wdata,
    output logic [63:0]      entry_pc,
    output logic             cpu_run,
    output logic             load_done,
    output logic             load_error,
    output logic [CNT_W-1:0] byte_count
);

    typedef enum logic [2:0] {
        StIdle,
        StHdr,
        StBody,
        StDrain,
        StRun,
        StErr
    } state_e;

    localparam logic [CNT_W-1:0] MemLimit = CNT_W'(MEM_BYTES);

    state_e           state_q, state_d;
    logic [2:0]       hdr_idx_q, hdr_idx_d;
    logic [63:0]      entry_pc_q, entry_pc_d;
    logic [CNT_W-1:0] byte_count_q, byte_count_d;
    logic             mem_we_q, mem_we_d;
    logic [CNT_W-1:0] mem_addr_q, mem_addr_d;
    logic [7:0]       mem_wdata_q, mem_wdata_d;
    logic             cpu_run_q, cpu_run_d;
    logic             load_done_q, load_done_d;
    logic             load_error_q, load_error_d;
`ifdef IMEM_LOADER_CKSUM_EN
    logic [7:0]       cksum_q, cksum_d;
`endif

    logic accept;

    assign in_ready = (state_q == StHdr) || (state_q == StBody);
    assign accept   = in_valid && in_ready;

    always_comb begin
        state_d      = state_q;
        hdr_idx_d    = hdr_idx_q;
        entry_pc_d   = entry_pc_q;
        byte_count_d = byte_count_q;
        mem_we_d     = 1'b0;
        mem_addr_d   = mem_addr_q;
        mem_wdata_d  = mem_wdata_q;
        cpu_run_d    = cpu_run_q;
        load_done_d  = load_done_q;
        load_error_d = load_error_q;
`ifdef IMEM_LOADER_CKSUM_EN
        cksum_d      = cksum_q;
`endif

        // A restart request overrides whatever byte may be on the stream this cycle.
        if (load_req) begin
            state_d      = StHdr;
            hdr_idx_d    = 3'd0;
            entry_pc_d   = 64'd0;
            byte_count_d = '0;
            cpu_run_d    = 1'b0;
            load_done_d  = 1'b0;
            load_error_d = 1'b0;
`ifdef IMEM_LOADER_CKSUM_EN
            cksum_d      = 8'd0;
`endif
        end else begin
            unique case (state_q)
                StIdle: ;
                StHdr: begin
                    if (accept) begin
                        entry_pc_d[{hdr_idx_q, 3'b000} +: 8] = in_data;
                        hdr_idx_d = hdr_idx_q + 3'd1;
`ifdef IMEM_LOADER_CKSUM_EN
                        cksum_d   = cksum_q ^ in_data;
`endif
                        if (in_last) begin
                            state_d      = StErr;
                            load_error_d = 1'b1;
                        end else if (hdr_idx_q == 3'd7) begin
                            state_d = StBody;
                        end
                    end
                end
                StBody: begin
                    if (accept) begin
`ifdef IMEM_LOADER_CKSUM_EN
                        if (in_last) begin
                            if ((byte_count_q == '0) || (cksum_q != in_data)) begin
                                state_d      = StErr;
                                load_error_d = 1'b1;
                            end else begin
                                state_d     = StRun;
                                cpu_run_d   = 1'b1;
                                load_done_d = 1'b1;
                            end
                        end else if (byte_count_q == MemLimit) begin
                            state_d      = StErr;
                            load_error_d = 1'b1;
                        end else begin
                            mem_we_d     = 1'b1;
                            mem_addr_d   = byte_count_q;
                            mem_wdata_d  = in_data;
                            byte_count_d = byte_count_q + CNT_W'(1);
                            cksum_d      = cksum_q ^ in_data;
                        end
`else
                        if (byte_count_q == MemLimit) begin
                            state_d      = StErr;
                            load_error_d = 1'b1;
                        end else begin
                            mem_we_d     = 1'b1;
                            mem_addr_d   = byte_count_q;
                            mem_wdata_d  = in_data;
                            byte_count_d = byte_count_q + CNT_W'(1);
                            if (in_last) begin
                                state_d = StDrain;
                            end
                        end
`endif
                    end
                end
                // Final write is on the bus this cycle; release the core once it has landed.
                StDrain: begin
                    state_d     = StRun;
                    cpu_run_d   = 1'b1;
                    load_done_d = 1'b1;
                end
                StRun: ;
                StErr: ;
                default: state_d = StIdle;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= StIdle;
            hdr_idx_q    <= 3'd0;
            entry_pc_q   <= 64'd0;
            byte_count_q <= '0;
            mem_we_q     <= 1'b0;
            mem_addr_q   <= '0;
            mem_wdata_q  <= 8'd0;
            cpu_run_q    <= 1'b0;
            load_done_q  <= 1'b0;
            load_error_q <= 1'b0;
`ifdef IMEM_LOADER_CKSUM_EN
            cksum_q      <= 8'd0;
`endif
        end else begin
            state_q      <= state_d;
            hdr_idx_q    <= hdr_idx_d;
            entry_pc_q   <= entry_pc_d;
            byte_count_q <= byte_count_d;
            mem_we_q     <= mem_we_d;
            mem_addr_q   <= mem_addr_d;
            mem_wdata_q  <= mem_wdata_d;
            cpu_run_q    <= cpu_run_d;
            load_done_q  <= load_done_d;
            load_error_q <= load_error_d;
`ifdef IMEM_LOADER_CKSUM_EN
            cksum_q      <= cksum_d;
`endif
        end
    end

    assign mem_we     = mem_we_q;
    assign mem_addr   = {{(64 - CNT_W){1'b0}}, mem_addr_q};
    assign mem_wdata  = mem_wdata_q;
    assign entry_pc   = entry_pc_q;
    assign cpu_run    = cpu_run_q;
    assign load_done  = load_done_q;
    assign load_error = load_error_q;
    assign byte_count = byte_count_q;

endmodule
